// File: rtl/dflow_qdr_replay_engine.sv
// rtl/dflow_qdr_replay_engine.sv - QDR tuple replay: credit-limited reads into a FWFT output FIFO
module dflow_qdr_replay_engine #(
    parameter int PKT_TUPLE_WIDTH = 104,
    parameter int PKT_LEN_WIDTH   = 16,
    parameter int QDR_ADDR_WIDTH  = 19,
    parameter int QDR_WORD_WIDTH  = 144,
    parameter int FIFO_DEPTH      = 16,
    parameter int LOOP_WIDTH      = 16
) (
    input  logic                       qdr_clk,
    input  logic                       resetn,
    input  logic                       sw_rst,
    input  logic                       start_replay,
    input  logic [LOOP_WIDTH-1:0]      replay_loops,
    input  logic [QDR_ADDR_WIDTH-1:0]  mem_addr_low,
    input  logic [QDR_ADDR_WIDTH-1:0]  mem_addr_high,
    input  logic                       init_calib_complete,
    output logic                       user_app_rd_cmd,
    output logic [QDR_ADDR_WIDTH-1:0]  user_app_rd_addr,
    input  logic                       user_app_rd_valid,
    input  logic [QDR_WORD_WIDTH-1:0]  user_app_rd_data,
    output logic [PKT_TUPLE_WIDTH-1:0] fivetuple_data_out,
    output logic [PKT_LEN_WIDTH-1:0]   pkt_len_out,
    output logic                       tuple_out_vld,
    input  logic                       tuple_out_ready,
    output logic                       compelete_replay,
    output logic                       replay_busy,
    output logic [LOOP_WIDTH-1:0]      loop_count
);
    localparam int REC_W = PKT_TUPLE_WIDTH + PKT_LEN_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_CAL = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_DRAIN    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic                      rst;
    logic                      start_q;
    logic                      start_edge;
    logic [2:0]                state_q, state_d;
    logic [QDR_ADDR_WIDTH-1:0] low_q, high_q;
    logic [QDR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LOOP_WIDTH-1:0]     loops_q;
    logic [LOOP_WIDTH-1:0]     loop_cnt_q, loop_cnt_d, loop_inc;
    logic                      load_cfg;
    logic [CNT_W-1:0]          outst_q;
    logic [5:0]                drop_q;
    logic                      rd_accept;
    logic                      pend_vld_q;
    logic [REC_W-1:0]          pend_data_q;
    logic [REC_W-1:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]          fcnt_q;
    logic                      push, pop;
    logic [CNT_W:0]            in_flight;
    logic                      unused_rsvd;

    assign rst         = !resetn || sw_rst;
    assign start_edge  = start_replay && !start_q;
    assign unused_rsvd = ^user_app_rd_data[QDR_WORD_WIDTH-1:REC_W+1];

    // Words already granted but not yet counted by the FIFO (in flight or staged) consume credit too.
    assign in_flight = {1'b0, outst_q} + {1'b0, fcnt_q} + {{CNT_W{1'b0}}, pend_vld_q};
    assign user_app_rd_cmd  = (state_q == S_ISSUE) && start_replay && (in_flight < DEPTH_C);
    assign user_app_rd_addr = user_app_rd_cmd ? addr_q : '0;

    assign rd_accept = user_app_rd_valid && (outst_q != '0) && (drop_q == 6'd0);
    assign push      = pend_vld_q;
    assign pop       = (fcnt_q != '0) && tuple_out_ready;

    assign tuple_out_vld      = (fcnt_q != '0);
    assign fivetuple_data_out = tuple_out_vld ? mem[rd_ptr_q][REC_W-1:PKT_LEN_WIDTH] : '0;
    assign pkt_len_out        = tuple_out_vld ? mem[rd_ptr_q][PKT_LEN_WIDTH-1:0] : '0;
    assign compelete_replay   = (state_q == S_DONE);
    assign replay_busy        = (state_q != S_IDLE);
    assign loop_count         = loop_cnt_q;

    assign load_cfg = (state_q == S_IDLE) && start_edge;
    assign loop_inc = (&loop_cnt_q) ? loop_cnt_q : loop_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        loop_cnt_d = loop_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d    = S_WAIT_CAL;
                    loop_cnt_d = '0;
                end
            end
            S_WAIT_CAL: begin
                // Issue is held off until the post-reset straggler window closes.
                if (low_q > high_q)
                    state_d = S_DONE;
                else if (!start_replay)
                    state_d = S_DRAIN;
                else if (init_calib_complete && drop_q == 6'd0) begin
                    addr_d  = low_q;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!start_replay)
                    state_d = S_DRAIN;
                else if (user_app_rd_cmd) begin
                    if (addr_q == high_q) begin
                        loop_cnt_d = loop_inc;
                        addr_d     = low_q;
                        if (loops_q != '0 && loop_inc == loops_q)
                            state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (outst_q == '0 && fcnt_q == '0 && !pend_vld_q)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (!start_replay)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge qdr_clk) begin
        if (rst) begin
            start_q     <= 1'b0;
            state_q     <= S_IDLE;
            low_q       <= '0;
            high_q      <= '0;
            loops_q     <= '0;
            addr_q      <= '0;
            loop_cnt_q  <= '0;
            outst_q     <= '0;
            drop_q      <= 6'd32;
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
        end else begin
            start_q    <= start_replay;
            state_q    <= state_d;
            addr_q     <= addr_d;
            loop_cnt_q <= loop_cnt_d;
            if (load_cfg) begin
                low_q   <= mem_addr_low;
                high_q  <= mem_addr_high;
                loops_q <= replay_loops;
            end
            if (drop_q != 6'd0)
                drop_q <= drop_q - 6'd1;
            case ({user_app_rd_cmd, rd_accept})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: outst_q <= outst_q;
            endcase
            pend_vld_q  <= rd_accept && user_app_rd_data[REC_W];
            pend_data_q <= user_app_rd_data[REC_W-1:0];
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    always_ff @(posedge qdr_clk) begin
        if (push)
            mem[wr_ptr_q] <= pend_data_q;
    end
endmodule

// File: tb/tb_dflow_qdr_replay_engine.sv
// tb/tb_dflow_qdr_replay_engine.sv - directed bench with QDR responder and replay model
module tb_dflow_qdr_replay_engine;
    localparam int LAT = 5;

    logic          qdr_clk = 1'b0;
    logic          resetn, sw_rst, start_replay, init_calib_complete;
    logic [15:0]   replay_loops;
    logic [18:0]   mem_addr_low, mem_addr_high;
    logic          user_app_rd_cmd;
    logic [18:0]   user_app_rd_addr;
    logic          user_app_rd_valid;
    logic [143:0]  user_app_rd_data;
    logic [103:0]  fivetuple_data_out;
    logic [15:0]   pkt_len_out;
    logic          tuple_out_vld, tuple_out_ready;
    logic          compelete_replay, replay_busy;
    logic [15:0]   loop_count;

    dflow_qdr_replay_engine dut (
        .qdr_clk(qdr_clk), .resetn(resetn), .sw_rst(sw_rst),
        .start_replay(start_replay), .replay_loops(replay_loops),
        .mem_addr_low(mem_addr_low), .mem_addr_high(mem_addr_high),
        .init_calib_complete(init_calib_complete),
        .user_app_rd_cmd(user_app_rd_cmd), .user_app_rd_addr(user_app_rd_addr),
        .user_app_rd_valid(user_app_rd_valid), .user_app_rd_data(user_app_rd_data),
        .fivetuple_data_out(fivetuple_data_out), .pkt_len_out(pkt_len_out),
        .tuple_out_vld(tuple_out_vld), .tuple_out_ready(tuple_out_ready),
        .compelete_replay(compelete_replay), .replay_busy(replay_busy),
        .loop_count(loop_count)
    );

    always #5 qdr_clk = ~qdr_clk;

    int checks = 0, passed = 0;
    int cyc = 0;
    logic [15:0] inv_mask = '0;
    logic [18:0] exp_addr[$];
    int cmd_idx, out_pos, n_cmd, n_out, n_rv;
    int first_rv, first_vld, first_cmd_cyc, last_cmd_cyc;
    bit straggler_win = 0;
    bit hold_prev = 0;
    logic [119:0] prev_data;

    typedef struct { logic [18:0] a; int due; } rq_t;
    rq_t rq[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        checks++;
        $display("FAIL %s: condition not met", name);
    endtask

    function automatic bit rec_valid(input logic [18:0] a);
        return !(a < 19'd16 && inv_mask[a[3:0]]);
    endfunction

    function automatic logic [143:0] rec(input logic [18:0] a);
        logic [103:0] t;
        logic [15:0]  l;
        t = {a, 66'h0, a ^ 19'h2AAAA};
        l = a[15:0] ^ 16'hBEEF;
        return {23'h7FFFFF, rec_valid(a), t, l};
    endfunction

    // Reference address stream derived directly from low/high/loops.
    task automatic setup_model(input logic [18:0] lo, input logic [18:0] hi, input logic [15:0] loops);
        logic [18:0] a;
        int lc;
        exp_addr.delete();
        a = lo;
        lc = 0;
        if (lo <= hi) begin
            while (exp_addr.size() < 400) begin
                exp_addr.push_back(a);
                if (a == hi) begin
                    lc++;
                    a = lo;
                    if (loops != 0 && lc == int'(loops)) break;
                end else a = a + 19'd1;
            end
        end
        cmd_idx = 0; out_pos = 0; n_cmd = 0; n_out = 0;
        first_rv = -1; first_vld = -1; first_cmd_cyc = -1; last_cmd_cyc = -1;
        mem_addr_low = lo; mem_addr_high = hi; replay_loops = loops;
    endtask

    // QDR responder: in-order, fixed latency, survives DUT reset.
    always @(negedge qdr_clk)
        if (user_app_rd_cmd) rq.push_back('{user_app_rd_addr, cyc + LAT});

    always @(posedge qdr_clk) begin
        cyc++;
        #1;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            user_app_rd_valid = 1'b1;
            user_app_rd_data  = rec(rq[0].a);
            void'(rq.pop_front());
        end else begin
            user_app_rd_valid = 1'b0;
            user_app_rd_data  = '0;
        end
    end

    always @(negedge qdr_clk) begin
        if (user_app_rd_valid) begin
            n_rv++;
            if (first_rv < 0) first_rv = cyc;
        end
        if (tuple_out_vld && first_vld < 0) first_vld = cyc;
        if (user_app_rd_cmd) begin
            if (cmd_idx < exp_addr.size()) chk("rd_addr", user_app_rd_addr, exp_addr[cmd_idx]);
            else fail("rd_cmd_unexpected");
            cmd_idx++; n_cmd++;
            if (first_cmd_cyc < 0) first_cmd_cyc = cyc;
            last_cmd_cyc = cyc;
        end
        if (straggler_win) chk("no_vld_after_reset", tuple_out_vld, 1'b0);
        if (hold_prev && tuple_out_vld) chk("hold_stable", {fivetuple_data_out, pkt_len_out}, prev_data);
        if (tuple_out_vld && tuple_out_ready && !straggler_win) begin
            while (out_pos < exp_addr.size() && !rec_valid(exp_addr[out_pos])) out_pos++;
            if (out_pos < exp_addr.size())
                chk("tuple_data", {fivetuple_data_out, pkt_len_out}, rec(exp_addr[out_pos])[119:0]);
            else fail("tuple_unexpected");
            out_pos++; n_out++;
        end
        hold_prev = tuple_out_vld && !tuple_out_ready;
        prev_data = {fivetuple_data_out, pkt_len_out};
    end

    task automatic tick(input int n);
        repeat (n) @(posedge qdr_clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge qdr_clk);
            if (compelete_replay) begin seen = 1; break; end
        end
        if (!seen) fail("wait_done_timeout");
        @(posedge qdr_clk);
        #1;
    endtask

    task automatic wait_cmds(input int n, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge qdr_clk);
            #1;
            if (n_cmd >= n) begin seen = 1; break; end
        end
        if (!seen) fail("wait_cmds_timeout");
        @(posedge qdr_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_cmd"}, user_app_rd_cmd, 1'b0);
        chk({tag, "_rd_addr"}, user_app_rd_addr, 19'd0);
        chk({tag, "_vld"}, tuple_out_vld, 1'b0);
        chk({tag, "_tuple"}, {fivetuple_data_out, pkt_len_out}, 120'd0);
        chk({tag, "_complete"}, compelete_replay, 1'b0);
        chk({tag, "_busy"}, replay_busy, 1'b0);
        chk({tag, "_loop_count"}, loop_count, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cyc;
        resetn = 0; sw_rst = 0; start_replay = 0; init_calib_complete = 0;
        tuple_out_ready = 1; replay_loops = 0; mem_addr_low = 0; mem_addr_high = 0;
        user_app_rd_valid = 0; user_app_rd_data = '0;
        setup_model(0, 0, 1);
        tick(3);
        check_all_zero("reset");
        resetn = 1;

        // Basic replay, also holding in WAIT_CAL until calibration completes.
        inv_mask = 16'h0000;
        setup_model(0, 3, 1);
        start_replay = 1;
        tick(6);
        chk("wait_cal_no_cmd", n_cmd, 0);
        chk("wait_cal_busy", replay_busy, 1'b1);
        init_calib_complete = 1;
        wait_done(300);
        chk("basic_cmds", n_cmd, 4);
        chk("basic_consecutive", last_cmd_cyc - first_cmd_cyc, 3);
        chk("basic_outs", n_out, 4);
        chk("basic_loop_count", loop_count, 16'd1);
        chk("basic_latency", first_vld - first_rv, 2);
        tick(3);
        chk("basic_done_held", compelete_replay, 1'b1);
        start_replay = 0;
        tick(1);
        chk("basic_done_clear", compelete_replay, 1'b0);
        chk("basic_idle", replay_busy, 1'b0);

        // Multiple loops over a two-record window.
        setup_model(10, 11, 3);
        start_replay = 1;
        wait_done(300);
        chk("loops_cmds", n_cmd, 6);
        chk("loops_outs", n_out, 6);
        chk("loops_loop_count", loop_count, 16'd3);
        start_replay = 0;
        tick(2);

        // Records 1 and 2 carry a cleared valid flag.
        inv_mask = 16'h0006;
        setup_model(0, 3, 1);
        start_replay = 1;
        wait_done(300);
        chk("inv_cmds", n_cmd, 4);
        chk("inv_outs", n_out, 2);
        start_replay = 0;
        tick(2);
        inv_mask = 16'h0000;

        // Empty window: low above high.
        setup_model(5, 4, 1);
        start_replay = 1;
        wait_done(100);
        chk("empty_cmds", n_cmd, 0);
        start_replay = 0;
        tick(2);

        // Abort with three reads in flight.
        setup_model(0, 15, 0);
        start_replay = 1;
        wait_cmds(3, 100);
        start_replay = 0;
        done_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge qdr_clk);
            if (compelete_replay) done_cyc++;
            if (done_cyc > 0 && !replay_busy) break;
        end
        chk("abort_cmds", n_cmd, 3);
        chk("abort_outs", n_out, 3);
        chk("abort_done_cycles", done_cyc, 1);
        chk("abort_idle", replay_busy, 1'b0);
        tick(2);

        // Backpressure: credit caps commands at the FIFO depth.
        setup_model(0, 99, 0);
        tuple_out_ready = 0;
        start_replay = 1;
        tick(60);
        chk("bp_cmds", n_cmd, 16);
        chk("bp_vld", tuple_out_vld, 1'b1);
        chk("bp_outs", n_out, 0);
        tuple_out_ready = 1;
        tick(30);
        start_replay = 0;
        wait_done(300);
        chk("bp_resumed", n_cmd > 16, 1'b1);
        chk("bp_no_loss", n_out, n_cmd);
        tick(2);

        // Hard reset mid-replay with reads in flight.
        setup_model(0, 15, 0);
        start_replay = 1;
        wait_cmds(8, 100);
        resetn = 0;
        start_replay = 0;
        tick(1);
        resetn = 1;
        n_rv = 0;
        straggler_win = 1;
        check_all_zero("mid_reset");
        tick(15);
        straggler_win = 0;
        chk("stragglers_seen", n_rv > 0, 1'b1);
        setup_model(0, 3, 1);
        start_replay = 1;
        wait_done(300);
        chk("post_reset_cmds", n_cmd, 4);
        chk("post_reset_outs", n_out, 4);
        chk("post_reset_loop_count", loop_count, 16'd1);
        start_replay = 0;
        tick(2);

        // Software reset behaves like resetn.
        setup_model(0, 15, 0);
        start_replay = 1;
        wait_cmds(4, 200);
        sw_rst = 1;
        start_replay = 0;
        tick(1);
        sw_rst = 0;
        straggler_win = 1;
        check_all_zero("sw_reset");
        tick(15);
        straggler_win = 0;
        tick(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
